// File: rtl/reset_sequencer.sv
// Board reset sequencer: timed CPU then PCIe A/B/C reset release off a slow ce timebase, with CSR restart/hold-mask.
// Outputs are registered from next-state, so they move on the same clk edge as the state; no backpressure.
module reset_sequencer #(
   parameter logic [4:0] BASE_ADDR  = 5'h1d,
   parameter logic [7:0] HOLD_TICKS = 8'd32,
   parameter logic [7:0] STEP_TICKS = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic       pwr_enable,
   input  logic       reset_req,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   output logic       hreset,
   output logic [2:0] pcie_rst,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HOLD   = 3'd1,
      S_CPU    = 3'd2,
      S_PCIE_A = 3'd3,
      S_PCIE_B = 3'd4,
      S_PCIE_C = 3'd5,
      S_RUN    = 3'd6
   } state_t;

   localparam logic [7:0] HOLD_LOAD = HOLD_TICKS - 8'd1;
   localparam logic [7:0] STEP_LOAD = STEP_TICKS - 8'd1;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] mask_q, mask_d;
   logic       hreset_q, hreset_d;
   logic [2:0] pcie_rst_q, pcie_rst_d;
   logic       done_q, done_d;

   logic       csr_wr;
   logic       restart;
   state_t     adv_state;
   logic [7:0] adv_load;
   logic       unused_csr_di;

   assign csr_wr        = csr_we && (csr_a == BASE_ADDR);
   assign restart       = reset_req || (csr_wr && csr_di[0]);
   assign unused_csr_di = ^csr_di[7:4];

   // Successor of the current timed state and the count it starts with.
   always_comb begin
      adv_state = state_q;
      adv_load  = 8'd0;
      case (state_q)
         S_HOLD:   begin adv_state = S_CPU;    adv_load = STEP_LOAD; end
         S_CPU:    begin adv_state = S_PCIE_A; adv_load = STEP_LOAD; end
         S_PCIE_A: begin adv_state = S_PCIE_B; adv_load = STEP_LOAD; end
         S_PCIE_B: begin adv_state = S_PCIE_C; adv_load = 8'd0;      end
         S_PCIE_C: begin adv_state = S_RUN;    adv_load = 8'd0;      end
         S_RUN:    begin adv_state = S_RUN;    adv_load = 8'd0;      end
         default:  begin adv_state = S_IDLE;   adv_load = 8'd0;      end
      endcase
   end

   // Priority: power loss, then power-up from IDLE, then restart, then ce timing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      if (csr_wr) begin
         mask_d = csr_di[3:1];
      end
      if (!pwr_enable) begin
         state_d = S_IDLE;
         cnt_d   = 8'd0;
      end else if (state_q == S_IDLE) begin
         state_d = S_HOLD;
         cnt_d   = HOLD_LOAD;
      end else if (restart) begin
         state_d = S_HOLD;
         cnt_d   = HOLD_LOAD;
      end else if (ce) begin
         if (cnt_q == 8'd0) begin
            state_d = adv_state;
            cnt_d   = adv_load;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_comb begin
      hreset_d      = (state_d == S_IDLE) || (state_d == S_HOLD);
      pcie_rst_d[0] = !(state_d inside {S_PCIE_A, S_PCIE_B, S_PCIE_C, S_RUN}) || mask_d[0];
      pcie_rst_d[1] = !(state_d inside {S_PCIE_B, S_PCIE_C, S_RUN}) || mask_d[1];
      pcie_rst_d[2] = !(state_d inside {S_PCIE_C, S_RUN}) || mask_d[2];
      done_d        = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         mask_q     <= 3'b000;
         hreset_q   <= 1'b1;
         pcie_rst_q <= 3'b111;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         hreset_q   <= hreset_d;
         pcie_rst_q <= pcie_rst_d;
         done_q     <= done_d;
      end
   end

   assign hreset   = hreset_q;
   assign pcie_rst = pcie_rst_q;
   assign done     = done_q;
   assign csr_do   = (csr_a == BASE_ADDR) ? {done_q, state_q, mask_q, 1'b0} : 8'h00;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 5'h1d: CSR address of the control/status register.
REQ-002 Parameter HOLD_TICKS, default 8'd32: ce ticks of CPU reset hold after power-good (about 1 ms at 32 kHz); legal range 1..255.
REQ-003 Parameter STEP_TICKS, default 8'd4: ce ticks between successive reset releases; legal range 1..255.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port ce, input, 1: one-clk-wide timebase strobe (ce_32khz).
REQ-007 Port pwr_enable, input, 1: board power on; low forces the sequence to IDLE.
REQ-008 Port reset_req, input, 1: one-clk pulse restarting the sequence (watchdog strobe, reset_req extender output).
REQ-009 Ports csr_a, input, 5; csr_di, input, 8; csr_we, input, 1: CSR bus from the I2C slave.
REQ-010 Port csr_do, output, 8: read data, OR-combined at top level; it is 8'h00 whenever csr_a != BASE_ADDR.
REQ-011 Port hreset, output, 1: CPU reset, active-high, registered.
REQ-012 Port pcie_rst, output, 3: PCIe A/B/C resets (bit0=A), active-high, registered.
REQ-013 Port done, output, 1: high only in state RUN, registered.

Function
REQ-014 FSM states, with the code exposed in CSR bits [6:4]: IDLE=0, HOLD=1, CPU=2, PCIE_A=3, PCIE_B=4, PCIE_C=5, RUN=6.
REQ-015 Use an 8-bit down-counter, loaded on every state entry: HOLD_TICKS-1 for HOLD, STEP_TICKS-1 for CPU/PCIE_A/PCIE_B.
- On a ce cycle with the counter at 0, advance to the next state.
- On a ce cycle with the counter nonzero, decrement.
- Each timed state therefore lasts exactly N ce pulses.
REQ-016 Sequence:
- IDLE -> HOLD on the first clk with pwr_enable=1.
- HOLD -> CPU -> PCIE_A -> PCIE_B -> PCIE_C, each timed per REQ-015.
- PCIE_C -> RUN on the next ce.
- RUN holds until restart.
REQ-017 hreset=1 in IDLE and HOLD; 0 in all other states.
REQ-018 pcie_rst[0] is released (0) in states PCIE_A and later; pcie_rst[1] in PCIE_B and later; pcie_rst[2] in PCIE_C and later. Each bit is additionally forced to 1 while its hold-mask bit is set.
REQ-019 Outputs are registered from the state that is valid after the clock edge, so an output changes in the same cycle the state register changes (zero added latency).
REQ-020 reset_req=1, or a CSR write with csr_di[0]=1, in any state except IDLE sends the FSM to HOLD and reloads the counter. This includes a request arriving while already in HOLD.
REQ-021 pwr_enable=0 sends the FSM to IDLE in any state. When it coincides with a restart request, it takes priority.
REQ-022 Register at BASE_ADDR:
- bit0: write-1 software restart; reads 0.
- bits[3:1]: R/W PCIe hold mask for A/B/C.
- bits[6:4]: RO state code.
- bit7: RO done.
Writes to RO bits are ignored.
REQ-023 A mask write updates pcie_rst on the next clk in any state. Clearing a mask bit in RUN releases that reset immediately.
REQ-024 ce and a restart in the same cycle: the restart wins, and the counter loads HOLD_TICKS-1 without decrementing.

Reset
REQ-025 While rst=1: state=IDLE, counter=0, mask=3'b000, hreset=1, pcie_rst=3'b111, done=0. reset_req, ce and CSR writes are ignored.
REQ-026 rst asserted mid-sequence overrides everything on the next clk. After rst deasserts, the sequence restarts from IDLE.

Verification
All scenarios use HOLD_TICKS=4, STEP_TICKS=2, ce every 4 clk.
REQ-027 Nominal power-up: pwr_enable 0->1 ->
- HOLD entered next clk;
- hreset falls after 4 ce;
- pcie_rst goes 111 -> 110 -> 100 -> 000 at 2-ce spacing;
- done=1 on the next ce after 000;
- register read gives 8'hE0.
REQ-028 Mask 3'b010 (write 8'h04) before power-up -> in RUN, pcie_rst=3'b010. Then write 8'h00 -> pcie_rst=3'b000 one clk later; read gives 8'hE0.
REQ-029 reset_req pulse in RUN -> next clk: state HOLD, hreset=1, pcie_rst=111, done=0; full sequence repeats with identical timing.
REQ-030 pwr_enable=0 and reset_req together in PCIE_B -> IDLE (read 8'h00) and all resets asserted. Re-raising pwr_enable restarts from HOLD.
REQ-031 Software restart (write 8'h01) in the same cycle as ce during CPU state -> HOLD with full 4-ce hold, not 3. Bit0 reads back 0.
REQ-032 rst pulse during PCIE_A -> outputs at reset values next clk, mask cleared. Reads to csr_a != BASE_ADDR return 8'h00 throughout.
